// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : PC sequencer for a combinational instruction memory, feeding a
//           2-entry {pc, instr} buffer to decode over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] C_RESET_PC = AW'(RESET_PC);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t          state_q,      state_d;
  logic [AW-1:0]   pc_q,         pc_d;
  logic [1:0]      count_q,      count_d;
  logic [AW-1:0]   head_pc_q,    head_pc_d;
  logic [31:0]     head_instr_q, head_instr_d;
  logic [AW-1:0]   tail_pc_q,    tail_pc_d;
  logic [31:0]     tail_instr_q, tail_instr_d;

  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_slot;

  assign instr_addr  = {{(32-AW){1'b0}}, pc_q};
  assign fetch_valid = (count_q != 2'd0);
  assign fetch_pc    = {{(32-AW){1'b0}}, head_pc_q};
  assign fetch_instr = head_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    w_pop  = fetch_valid & fetch_ready;
    w_push = (state_q == ST_FETCH) & ((count_q < 2'd2) | w_pop) & ~redirect_valid;
    // Slot index the new entry lands in once this cycle's pop is removed.
    w_slot = w_pop ? (count_q - 2'd1) : count_q;

    state_d = run ? ST_FETCH : ST_IDLE;

    if (redirect_valid) begin
      // Flush; head registers keep their last values for observability.
      count_d = 2'd0;
      pc_d    = redirect_pc[AW-1:0];
    end else begin
      if (w_pop && (count_q == 2'd2)) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end
      if (w_push) begin
        pc_d = pc_q + AW'(1);
        if (w_slot == 2'd0) begin
          head_pc_d    = pc_q;
          head_instr_d = instr;
        end else begin
          tail_pc_d    = pc_q;
          tail_instr_d = instr;
        end
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= C_RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

endmodule
`default_nettype wire
